// File: rtl/wallace_reduce_pipe_if.sv
// wallace_reduce_pipe_if: operand/result stream bundle for the Wallace reduction pipe.
interface wallace_reduce_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   sum_vec;
    logic [2*DATA_W-1:0]   carry_vec;
    logic [TAG_W-1:0]      out_tag;
    modport master (
        output in_valid, a, b, in_tag, out_ready,
        input  in_ready, out_valid, sum_vec, carry_vec, out_tag
    );
    modport slave (
        input  in_valid, a, b, in_tag, out_ready,
        output in_ready, out_valid, sum_vec, carry_vec, out_tag
    );
endinterface

// File: rtl/wallace_reduce_pipe.sv
// wallace_reduce_pipe: 3-stage 16x16 partial-product generation and 3:2 reduction to two rows.
// Optional stall counter output perf_stall when WALLACE_PERF_EN is defined.
module wallace_reduce_pipe #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input logic clk,
    input logic rst_n,
    wallace_reduce_pipe_if.slave bus
`ifdef WALLACE_PERF_EN
    , output logic [15:0] perf_stall
`endif
);
    localparam int W = 2 * DATA_W;
    logic              advance;
    logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]  t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic [W-1:0]      r2_q [6];
    logic [W-1:0]      r2_d [6];
    logic [W-1:0]      sum_q, sum_d, carry_q, carry_d;
    logic [W-1:0]      l0 [16];
    logic [W-1:0]      l1 [11];
    logic [W-1:0]      l2 [8];
    logic [W-1:0]      l3 [6];
    logic [W-1:0]      l4 [4];
    logic [W-1:0]      l5 [3];

    // Carry row is shifted to its weight; the column-31 carry falls off the top.
    function automatic logic [2*W-1:0] csa(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] z);
        return {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
    endfunction

    always_comb begin
        advance = ~v3_q | bus.out_ready;
        v1_d = advance ? bus.in_valid : v1_q;
        a_d  = advance ? bus.a : a_q;
        b_d  = advance ? bus.b : b_q;
        t1_d = advance ? bus.in_tag : t1_q;
        v2_d = advance ? v1_q : v2_q;
        t2_d = advance ? t1_q : t2_q;
        v3_d = advance ? v2_q : v3_q;
        t3_d = advance ? t2_q : t3_q;
        for (int i = 0; i < 16; i++) l0[i] = {{DATA_W{1'b0}}, a_q & {DATA_W{b_q[i]}}} << i;
        for (int g = 0; g < 5; g++) {l1[2*g], l1[2*g+1]} = csa(l0[3*g], l0[3*g+1], l0[3*g+2]);
        l1[10] = l0[15];
        for (int g = 0; g < 3; g++) {l2[2*g], l2[2*g+1]} = csa(l1[3*g], l1[3*g+1], l1[3*g+2]);
        l2[6] = l1[9];
        l2[7] = l1[10];
        for (int g = 0; g < 2; g++) {l3[2*g], l3[2*g+1]} = csa(l2[3*g], l2[3*g+1], l2[3*g+2]);
        l3[4] = l2[6];
        l3[5] = l2[7];
        for (int i = 0; i < 6; i++) r2_d[i] = advance ? l3[i] : r2_q[i];
        for (int g = 0; g < 2; g++) {l4[2*g], l4[2*g+1]} = csa(r2_q[3*g], r2_q[3*g+1], r2_q[3*g+2]);
        {l5[0], l5[1]} = csa(l4[0], l4[1], l4[2]);
        l5[2] = l4[3];
        {sum_d, carry_d} = advance ? csa(l5[0], l5[1], l5[2]) : {sum_q, carry_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            for (int i = 0; i < 6; i++) r2_q[i] <= '0;
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            for (int i = 0; i < 6; i++) r2_q[i] <= r2_d[i];
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v3_q;
    assign bus.sum_vec   = sum_q;
    assign bus.carry_vec = carry_q;
    assign bus.out_tag   = t3_q;

`ifdef WALLACE_PERF_EN
    logic [15:0] perf_q, perf_d;
    always_comb perf_d = (v3_q & ~bus.out_ready & ~&perf_q) ? perf_q + 16'd1 : perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end
    assign perf_stall = perf_q;
`endif
endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// tb_wallace_reduce_pipe: directed and randomized checks of the reduction pipe against a
// product/tag scoreboard.
module tb_wallace_reduce_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int retired = 0;

    typedef struct {
        logic [31:0] prod;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    logic [31:0] b2b_exp [3] = '{32'h06260060, 32'h00010000, 32'h00000000};

    always #5 clk = ~clk;

    wallace_reduce_pipe_if #(.DATA_W(16), .TAG_W(4)) bus ();
`ifdef WALLACE_PERF_EN
    logic [15:0] perf_stall;
`endif

    wallace_reduce_pipe #(.DATA_W(16), .TAG_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef WALLACE_PERF_EN
        , .perf_stall(perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] t);
        bus.in_valid = v;
        bus.a        = x;
        bus.b        = y;
        bus.in_tag   = t;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        chk("wait_out_valid", 64'(bus.out_valid), 64'd1);
    endtask

    // Scoreboard: accepts push a*b, retirements pop in order.
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                retired++;
                if (sb.size() == 0) chk("ret_extra", 64'(sb.size()), 64'd1);
                else begin
                    exp_t e;
                    logic [31:0] s;
                    e = sb.pop_front();
                    s = bus.sum_vec + bus.carry_vec;
                    chk("ret_prod", 64'(s), 64'(e.prod));
                    chk("ret_tag", 64'(bus.out_tag), 64'(e.tag));
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back('{prod: 32'(bus.a) * 32'(bus.b), tag: bus.in_tag});
        end
    end

    initial begin
        logic [31:0] s32, snap_s, snap_c;
        logic [32:0] s33;
        logic [3:0]  snap_t;
        logic        acc;
        int r0, pulses, sent, cyc;
        drive(0, 0, 0, 0);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum_vec), 64'd0);
        chk("rst_carry", 64'(bus.carry_vec), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef WALLACE_PERF_EN
        chk("rst_perf", 64'(perf_stall), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        drive(1, 16'h0003, 16'h0005, 4'd1);
        tick();
        drive(0, 0, 0, 0);
        chk("lat_edge1", 64'(bus.out_valid), 64'd0);
        tick();
        chk("lat_edge2", 64'(bus.out_valid), 64'd0);
        tick();
        chk("lat_edge3", 64'(bus.out_valid), 64'd1);
        s32 = bus.sum_vec + bus.carry_vec;
        chk("lat_sum", 64'(s32), 64'h0F);
        chk("lat_tag", 64'(bus.out_tag), 64'd1);
        tick();

        drive(1, 16'hFFFF, 16'hFFFF, 4'd2);
        tick();
        drive(0, 0, 0, 0);
        wait_out();
        s33 = {1'b0, bus.sum_vec} + {1'b0, bus.carry_vec};
        chk("max_sum33", 64'(s33), 64'h0FFFE0001);
        tick();

        drive(1, 16'h1234, 16'h5678, 4'd3);
        tick();
        drive(1, 16'h8000, 16'h0002, 4'd4);
        tick();
        drive(1, 16'h0000, 16'hABCD, 4'd5);
        tick();
        drive(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            s32 = bus.sum_vec + bus.carry_vec;
            chk("b2b_valid", 64'(bus.out_valid), 64'd1);
            chk("b2b_sum", 64'(s32), 64'(b2b_exp[k]));
            chk("b2b_tag", 64'(bus.out_tag), 64'(3 + k));
            tick();
        end
        tick();

        r0 = retired;
        drive(1, 16'h0101, 16'h0202, 4'd6);
        tick();
        drive(1, 16'hF00D, 16'h0F0F, 4'd7);
        tick();
        drive(1, 16'h7777, 16'h1111, 4'd8);
        tick();
        chk("stall_full", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        drive(1, 16'h00AA, 16'h0055, 4'd9);
        snap_s = bus.sum_vec;
        snap_c = bus.carry_vec;
        snap_t = bus.out_tag;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            chk("stall_sum", 64'(bus.sum_vec), 64'(snap_s));
            chk("stall_carry", 64'(bus.carry_vec), 64'(snap_c));
            chk("stall_tag", 64'(bus.out_tag), 64'(snap_t));
        end
`ifdef WALLACE_PERF_EN
        chk("stall_perf", 64'(perf_stall), 64'd5);
`endif
        bus.out_ready = 1'b1;
        tick();
        drive(0, 0, 0, 0);
        repeat (6) tick();
        chk("stall_retired", 64'(retired - r0), 64'd4);
        chk("stall_drain", 64'(sb.size()), 64'd0);

        drive(1, 16'h0033, 16'h0044, 4'd10);
        tick();
        drive(1, 16'h0055, 16'h0066, 4'd11);
        tick();
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ov", 64'(bus.out_valid), 64'd0);
`ifdef WALLACE_PERF_EN
        chk("rst_mid_perf", 64'(perf_stall), 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        drive(1, 16'h0010, 16'h0010, 4'd12);
        tick();
        drive(0, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) begin
                pulses++;
                s32 = bus.sum_vec + bus.carry_vec;
                chk("rst_mid_sum", 64'(s32), 64'h100);
            end
            tick();
        end
        chk("rst_mid_pulses", 64'(pulses), 64'd1);

        sent = 0;
        cyc = 0;
        drive(1, 16'($urandom), 16'($urandom), 4'($urandom));
        while (sent < 10000 && cyc < 40000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #3;
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
            tick();
            cyc++;
            if (acc || !bus.in_valid)
                drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 4'($urandom));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (8) tick();
        chk("rand_sent", 64'(sent), 64'd10000);
        chk("rand_drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
